// File: rtl/enemy_hit_sched.sv
// enemy_hit_sched
//   Shares one missile-vs-enemy bounding-box comparator among N enemies.
//   A scan runs once per frame_tick while a missile is in flight. It walks
//   the enemies in index order and kills the first alive enemy the missile
//   overlaps. At most one enemy dies per scan. The block also keeps the
//   per-enemy alive mask for the draw chain.
//
// Ports
//   pclk, rst                  pixel clock; async active-high reset
//   frame_tick                 one-cycle pulse that starts a scan (needs on_missile)
//   level_change               one-cycle pulse that revives all enemies and aborts a scan
//   on_missile                 missile in flight
//   xpos_missile, ypos_missile missile position
//   xpos_enemies               packed enemy centres, enemy k in [11k+10:11k]
//   ypos_enemies               packed enemy top edges, same packing
//   alive                      bit k set while enemy k is drawn
//   hit, missile_kill          coincident one-cycle pulses on a kill
//   hit_idx                    index of the last enemy killed; held between kills
//   level_clear                one-cycle pulse when the last alive enemy dies
//   busy                       scan in progress (registered copy of the state)
module enemy_hit_sched #(
  parameter int N                = 8,
  parameter int HALF_WIDTH_ENEMY = 25,
  parameter int HEIGHT_ENEMY     = 50,
  localparam int IW              = (N > 1) ? $clog2(N) : 1
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            frame_tick,
  input  logic            level_change,
  input  logic            on_missile,
  input  logic [10:0]     xpos_missile,
  input  logic [10:0]     ypos_missile,
  input  logic [11*N-1:0] xpos_enemies,
  input  logic [11*N-1:0] ypos_enemies,
  output logic [N-1:0]    alive,
  output logic            hit,
  output logic [IW-1:0]   hit_idx,
  output logic            missile_kill,
  output logic            level_clear,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [11:0]   HW12 = 12'(HALF_WIDTH_ENEMY);
  localparam logic [11:0]   HH12 = 12'(HEIGHT_ENEMY);

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic            clear_done;

  logic [10:0]     xe_arr [N];
  logic [10:0]     ye_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign xe_arr[g] = xpos_enemies[11*g +: 11];
    assign ye_arr[g] = ypos_enemies[11*g +: 11];
  end

  // The shared comparator sees only the enemy selected by idx. All operands
  // are widened to 12 bits and the half-width is added on whichever side
  // would otherwise need a subtraction. This avoids wrap-around near x = 0.
  logic [11:0] xm12, ym12, xe12, ye12;
  logic        overlap, cand;

  always_comb begin
    xm12    = {1'b0, xpos_missile};
    ym12    = {1'b0, ypos_missile};
    xe12    = {1'b0, xe_arr[idx]};
    ye12    = {1'b0, ye_arr[idx]};
    overlap = (xm12 + HW12 >= xe12) && (xm12 <= xe12 + HW12) &&
              (ym12 >= ye12)        && (ym12 <= ye12 + HH12);
    cand    = alive[idx] && overlap;
  end

  // FSM state register
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next state. level_change overrides everything, including a tick.
  always_comb begin
    state_nx = state;
    if (level_change) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (frame_tick && on_missile) state_nx = SCAN;
        SCAN:    if (cand || idx == LAST)      state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      alive        <= '1;
      hit          <= 1'b0;
      hit_idx      <= '0;
      missile_kill <= 1'b0;
      level_clear  <= 1'b0;
      busy         <= 1'b0;
      clear_done   <= 1'b0;
    end else begin
      hit          <= 1'b0;
      missile_kill <= 1'b0;
      level_clear  <= 1'b0;
      busy         <= (state != IDLE);
      if (level_change) begin
        alive      <= '1;
        clear_done <= 1'b0;
        idx        <= '0;
      end else begin
        case (state)
          IDLE: if (frame_tick && on_missile) idx <= '0;
          SCAN: begin
            if (cand) begin
              alive[idx]   <= 1'b0;
              hit_idx      <= idx;
              hit          <= 1'b1;
              missile_kill <= 1'b1;
            end else if (idx != LAST) begin
              idx <= idx + IW'(1);
            end
          end
          DONE: begin
            // The kill has already landed in alive, so an empty mask here
            // means this scan took the last enemy. clear_done stops a repeat
            // pulse on later empty scans until the next revive.
            if (alive == '0 && !clear_done) begin
              level_clear <= 1'b1;
              clear_done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_enemy_hit_sched.sv
// Scoreboard bench for enemy_hit_sched (N=4). The driver computes expected
// kills from a geometric reference model and queues them. A separate monitor
// compares them against hit/level_clear pulses as they appear. The monitor
// also checks queued alive/busy samples and reset values.
module tb_enemy_hit_sched;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            pclk = 1'b0;
  logic            rst = 1'b0;
  logic            frame_tick = 1'b0;
  logic            level_change = 1'b0;
  logic            on_missile = 1'b0;
  logic [10:0]     xpos_missile = '0;
  logic [10:0]     ypos_missile = '0;
  logic [11*N-1:0] xpos_enemies = '0;
  logic [11*N-1:0] ypos_enemies = '0;
  logic [N-1:0]    alive;
  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic            missile_kill;
  logic            level_clear;
  logic            busy;

  enemy_hit_sched #(.N(N), .HALF_WIDTH_ENEMY(25), .HEIGHT_ENEMY(50)) dut (
    .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .level_change(level_change),
    .on_missile(on_missile), .xpos_missile(xpos_missile), .ypos_missile(ypos_missile),
    .xpos_enemies(xpos_enemies), .ypos_enemies(ypos_enemies), .alive(alive),
    .hit(hit), .hit_idx(hit_idx), .missile_kill(missile_kill),
    .level_clear(level_clear), .busy(busy)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {int cyc; int idx; logic [N-1:0] alive;} hit_t;
  typedef struct {int cyc; bit chk_alive; logic [N-1:0] alive; bit chk_busy; logic busy;} st_t;

  hit_t hq[$];
  int   lq[$];
  st_t  sq[$];
  int   nvec = 0;
  int   nerr = 0;

  // reference model state
  int           ex[N], ey[N];
  int           mx, my;
  logic [N-1:0] m_alive = '1;
  bit           m_cd = 1'b0;

  // first alive enemy whose box contains the missile (signed int geometry)
  function automatic int find_hit();
    for (int k = 0; k < N; k++)
      if (m_alive[k] && mx >= ex[k] - 25 && mx <= ex[k] + 25 &&
          my >= ey[k] && my <= ey[k] + 50)
        return k;
    return -1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apply_pos();
    xpos_missile = 11'(mx);
    ypos_missile = 11'(my);
    for (int k = 0; k < N; k++) begin
      xpos_enemies[11*k +: 11] = 11'(ex[k]);
      ypos_enemies[11*k +: 11] = 11'(ey[k]);
    end
  endtask

  task automatic far();
    for (int k = 0; k < N; k++) begin
      ex[k] = 1500;
      ey[k] = 1800;
    end
  endtask

  task automatic revive();
    int c;
    c = cyc;
    level_change = 1'b1;
    m_alive = '1;
    m_cd = 1'b0;
    sq.push_back('{cyc: c + 1, chk_alive: 1'b1, alive: '1, chk_busy: 1'b0, busy: 1'b0});
    step(1);
    level_change = 1'b0;
  endtask

  // mode 0: plain scan, 1: extra tick mid-scan, 2: level_change mid-scan,
  // 3: async reset mid-scan
  task automatic frame(input bit onm, input int mode);
    int c, k;
    apply_pos();
    on_missile = onm;
    c = cyc;
    k = onm ? find_hit() : -1;
    if (mode < 2 && k >= 0) begin
      m_alive[k] = 1'b0;
      hq.push_back('{cyc: c + k + 2, idx: k, alive: m_alive});
      if (m_alive == '0 && !m_cd) begin
        m_cd = 1'b1;
        lq.push_back(c + k + 3);
      end
    end
    if (mode != 3)
      sq.push_back('{cyc: c + 2, chk_alive: 1'b0, alive: '0, chk_busy: 1'b1, busy: onm});
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    case (mode)
      1: begin
        step(1);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(N + 1);
      end
      2: begin
        step(1);
        level_change = 1'b1;
        m_alive = '1;
        m_cd = 1'b0;
        sq.push_back('{cyc: c + 3, chk_alive: 1'b1, alive: '1, chk_busy: 1'b0, busy: 1'b0});
        step(1);
        level_change = 1'b0;
        step(N + 1);
      end
      3: begin
        step(1);
        #1 rst = 1'b1;
        m_alive = '1;
        m_cd = 1'b0;
        step(1);
        #3 rst = 1'b0;
        step(N);
      end
      default: begin
        if (onm && $urandom_range(0, 1) == 1) on_missile = 1'b0;
        step(N + 2);
      end
    endcase
    if (mode != 3)
      sq.push_back('{cyc: cyc, chk_alive: 1'b0, alive: '0, chk_busy: 1'b1, busy: 1'b0});
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin : mon
    hit_t h;
    st_t  s;
    forever begin
      @(negedge pclk or posedge rst);
      if (rst) begin
        #1;
        chk("reset_state",
            int'({alive, hit, hit_idx, missile_kill, level_clear, busy}),
            int'({{N{1'b1}}, 1'b0, {IW{1'b0}}, 3'b000}));
      end else begin
        chk("kill_eq_hit", int'(missile_kill), int'(hit));
        while (hq.size() > 0 && hq[0].cyc < cyc) begin
          nvec++; nerr++;
          $display("FAIL hit_missing: expected idx %0d at cycle %0d, got none", hq[0].idx, hq[0].cyc);
          void'(hq.pop_front());
        end
        if (hit) begin
          if (hq.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL hit_unexpected: got hit idx %0d at cycle %0d, expected none", hit_idx, cyc);
          end else begin
            h = hq.pop_front();
            chk("hit_cycle", cyc, h.cyc);
            chk("hit_idx", int'(hit_idx), h.idx);
            chk("hit_alive", int'(alive), int'(h.alive));
          end
        end
        while (lq.size() > 0 && lq[0] < cyc) begin
          nvec++; nerr++;
          $display("FAIL clear_missing: expected level_clear at cycle %0d, got none", lq[0]);
          void'(lq.pop_front());
        end
        if (level_clear) begin
          if (lq.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL clear_unexpected: got level_clear at cycle %0d, expected none", cyc);
          end else begin
            chk("clear_cycle", cyc, lq.pop_front());
          end
        end
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
          s = sq.pop_front();
          if (s.cyc == cyc) begin
            if (s.chk_alive) chk("alive", int'(alive), int'(s.alive));
            if (s.chk_busy)  chk("busy", int'(busy), int'(s.busy));
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  int bx[7] = '{175, 225, 200, 174, 226, 200, 200};
  int by[7] = '{100, 150, 125, 100, 100,  99, 151};

  initial begin
    far();
    mx = 0; my = 0;
    apply_pos();
    #1 rst = 1'b1;
    step(2);
    #3 rst = 1'b0;
    step(2);

    // basic hit on enemy 2, then repeat tick finds it dead
    revive(); far();
    ex[2] = 200; ey[2] = 100; mx = 225; my = 150;
    frame(1'b1, 0);
    frame(1'b1, 0);

    // inclusive box edges
    for (int i = 0; i < 7; i++) begin
      revive(); far();
      ex[0] = 200; ey[0] = 100; mx = bx[i]; my = by[i];
      frame(1'b1, 0);
    end

    // no underflow near x = 0
    revive(); far();
    ex[1] = 10; ey[1] = 100; mx = 0; my = 120;
    frame(1'b1, 0);

    // overlapping enemies 1 and 3: lowest index dies first
    revive(); far();
    ex[1] = 300; ey[1] = 200; ex[3] = 300; ey[3] = 200; mx = 310; my = 220;
    frame(1'b1, 0);
    frame(1'b1, 0);

    // kill all four, one level_clear, none afterwards, then revive
    revive();
    for (int k = 0; k < N; k++) begin ex[k] = 500; ey[k] = 500; end
    mx = 500; my = 520;
    for (int i = 0; i < N + 1; i++) frame(1'b1, 0);
    revive();

    // tick without a missile does nothing
    frame(1'b0, 0);

    // tick during SCAN is ignored
    revive(); far();
    ex[2] = 600; ey[2] = 300; ex[3] = 600; ey[3] = 300; mx = 600; my = 300;
    frame(1'b1, 1);
    frame(1'b1, 0);

    // level_change mid-scan aborts before enemy 2 is killed
    revive(); far();
    ex[2] = 700; ey[2] = 400; mx = 700; my = 400;
    frame(1'b1, 2);
    frame(1'b1, 0);

    // async reset mid-scan, then the next scan restarts at index 0
    revive(); far();
    ex[0] = 800; ey[0] = 200; ex[3] = 800; ey[3] = 200; mx = 800; my = 200;
    frame(1'b1, 0);
    frame(1'b1, 3);
    frame(1'b1, 0);

    // randomized frames
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 5) == 0) revive();
      mx = int'($urandom_range(0, 400));
      my = int'($urandom_range(0, 400));
      for (int k = 0; k < N; k++) begin
        ex[k] = mx + int'($urandom_range(0, 70)) - 35;
        ey[k] = my - int'($urandom_range(0, 70)) + 10;
        if (ex[k] < 0) ex[k] = 0;
        if (ey[k] < 0) ey[k] = 0;
      end
      frame($urandom_range(0, 3) != 0, ($urandom_range(0, 9) == 0) ? 1 : 0);
    end

    step(6);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
